// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end sharing one combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (req0 wins).
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_negative,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_negative,
  output logic              rsp1_zero,
  output logic [DATA_W-1:0] alu_inputA,
  output logic [DATA_W-1:0] alu_inputB,
  output logic [OP_W-1:0]   alu_aluOP,
  input  logic [DATA_W-1:0] alu_ALUResult,
  input  logic              alu_negative,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              gnt_id;
  logic              accept;
  logic              owner_p0;
  logic [DATA_W-1:0] a_p0, b_p0;
  logic [OP_W-1:0]   op_p0;

`ifdef ALU_ARB_RR_EN
  logic last_grant;

  // Contested grant goes to whoever did not win last; reset value 1 hands the first one to req0.
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) gnt_id = ~last_grant;
    else if (req1_valid)          gnt_id = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nRst)       last_grant <= 1'b1;
    else if (accept) last_grant <= gnt_id;
  end
`else
  assign gnt_id = req1_valid & ~req0_valid;
`endif

  always_ff @(posedge clk) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Ready is only offered in IDLE and only to the granted requester, so ready implies acceptance.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (nRst && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = ~owner_p0;
        rsp1_valid = owner_p0;
        if (owner_p0 ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand latch; the ALU only ever sees these registers.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      owner_p0 <= 1'b0;
      a_p0     <= '0;
      b_p0     <= '0;
      op_p0    <= '0;
    end else if (accept) begin
      owner_p0 <= gnt_id;
      a_p0     <= gnt_id ? req1_a  : req0_a;
      b_p0     <= gnt_id ? req1_b  : req0_b;
      op_p0    <= gnt_id ? req1_op : req0_op;
    end
  end

  assign alu_inputA = a_p0;
  assign alu_inputB = b_p0;
  assign alu_aluOP  = op_p0;

  // Stage p1: capture the ALU return into the owner's response registers.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      rsp0_result   <= '0;
      rsp0_negative <= 1'b0;
      rsp0_zero     <= 1'b0;
      rsp1_result   <= '0;
      rsp1_negative <= 1'b0;
      rsp1_zero     <= 1'b0;
    end else if (state == EXEC) begin
      if (owner_p0) begin
        rsp1_result   <= alu_ALUResult;
        rsp1_negative <= alu_negative;
        rsp1_zero     <= alu_zero;
      end else begin
        rsp0_result   <= alu_ALUResult;
        rsp0_negative <= alu_negative;
        rsp0_zero     <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam logic [OP_W-1:0] CU_SLL = 6'h00;
  localparam logic [OP_W-1:0] CU_ADD = 6'h20;
  localparam logic [OP_W-1:0] CU_SUB = 6'h22;
  localparam logic [OP_W-1:0] CU_BAD = 6'h3F;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              nRst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp0_result, rsp1_result;
  logic              rsp0_negative, rsp0_zero, rsp1_negative, rsp1_zero;
  logic [DATA_W-1:0] alu_inputA, alu_inputB, alu_ALUResult;
  logic [OP_W-1:0]   alu_aluOP;
  logic              alu_negative, alu_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .nRst(nRst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_negative(rsp0_negative), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_negative(rsp1_negative), .rsp1_zero(rsp1_zero),
    .alu_inputA(alu_inputA), .alu_inputB(alu_inputB), .alu_aluOP(alu_aluOP),
    .alu_ALUResult(alu_ALUResult), .alu_negative(alu_negative), .alu_zero(alu_zero)
  );

  // Shared ALU: unknown opcodes return 0/0/0.
  always_comb begin
    alu_ALUResult = '0;
    alu_negative  = 1'b0;
    alu_zero      = 1'b0;
    case (alu_aluOP)
      CU_ADD: alu_ALUResult = alu_inputA + alu_inputB;
      CU_SUB: alu_ALUResult = alu_inputA - alu_inputB;
      CU_SLL: alu_ALUResult = alu_inputA << alu_inputB[4:0];
      default: alu_ALUResult = '0;
    endcase
    if (alu_aluOP == CU_ADD || alu_aluOP == CU_SUB || alu_aluOP == CU_SLL) begin
      alu_negative = alu_ALUResult[DATA_W-1];
      alu_zero     = (alu_ALUResult == '0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_g;
    nRst = 1'b0;
    req0_valid = 1'b1; req0_a = 5; req0_b = 3; req0_op = CU_ADD;
    req1_valid = 1'b0; req1_a = 0; req1_b = 0; req1_op = CU_SLL;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    cyc(); cyc();
    check("rst_req0_ready", 32'(req0_ready), 0);
    check("rst_req1_ready", 32'(req1_ready), 0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 0);
    check("rst_aluA", alu_inputA, 0);
    check("rst_rsp0_result", rsp0_result, 0);

    // single ADD on req0
    nRst = 1'b1; rsp0_ready = 1'b1; #1;
    check("add_req0_ready", 32'(req0_ready), 1);
    check("add_req1_ready", 32'(req1_ready), 0);
    cyc(); req0_valid = 1'b0;
    check("add_exec_rsp0_valid", 32'(rsp0_valid), 0);
    check("add_aluA", alu_inputA, 5);
    check("add_aluOP", 32'(alu_aluOP), 32'(CU_ADD));
    cyc();
    check("add_rsp0_valid", 32'(rsp0_valid), 1);
    check("add_result", rsp0_result, 8);
    check("add_zero", 32'(rsp0_zero), 0);
    check("add_neg", 32'(rsp0_negative), 0);
    check("add_rsp1_valid", 32'(rsp1_valid), 0);
    cyc();
    check("add_idle_rsp0_valid", 32'(rsp0_valid), 0);

    // operands changed after acceptance
    req0_a = 2; req0_b = 3; req0_op = CU_ADD; req0_valid = 1'b1;
    cyc(); req0_valid = 1'b0; req0_a = 9;
    cyc();
    check("opchg_result", rsp0_result, 5);
    cyc();

    // unknown opcode passes through
    req0_a = 5; req0_b = 3; req0_op = CU_BAD; req0_valid = 1'b1;
    cyc(); req0_valid = 1'b0;
    check("bad_aluOP", 32'(alu_aluOP), 32'(CU_BAD));
    cyc();
    check("bad_rsp0_valid", 32'(rsp0_valid), 1);
    check("bad_result", rsp0_result, 0);
    check("bad_zero", 32'(rsp0_zero), 0);
    check("bad_neg", 32'(rsp0_negative), 0);
    cyc();

    // contention after a fresh reset
    nRst = 1'b0; cyc(); nRst = 1'b1;
    req0_a = 7; req0_b = 7; req0_op = CU_SUB; req0_valid = 1'b1;
    req1_a = 1; req1_b = 4; req1_op = CU_SLL; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = RR ? (k % 2) : 0;
      #1;
      check($sformatf("cont%0d_req0_ready", k), 32'(req0_ready), 32'(exp_g == 0));
      check($sformatf("cont%0d_req1_ready", k), 32'(req1_ready), 32'(exp_g == 1));
      cyc(); cyc();
      check($sformatf("cont%0d_rsp0_valid", k), 32'(rsp0_valid), 32'(exp_g == 0));
      check($sformatf("cont%0d_rsp1_valid", k), 32'(rsp1_valid), 32'(exp_g == 1));
      if (exp_g == 0) begin
        check($sformatf("cont%0d_rsp0_result", k), rsp0_result, 0);
        check($sformatf("cont%0d_rsp0_zero", k), 32'(rsp0_zero), 1);
      end else begin
        check($sformatf("cont%0d_rsp1_result", k), rsp1_result, 16);
        check($sformatf("cont%0d_rsp1_zero", k), 32'(rsp1_zero), 0);
      end
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // backpressure on rsp1 with a negative result
    req1_a = 0; req1_b = 16; req1_op = CU_SUB; req1_valid = 1'b1; rsp1_ready = 1'b0;
    cyc(); req1_valid = 1'b0;
    req0_a = 5; req0_b = 3; req0_op = CU_ADD; req0_valid = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_rsp1_valid", i), 32'(rsp1_valid), 1);
      check($sformatf("bp%0d_rsp1_result", i), rsp1_result, 32'hFFFF_FFF0);
      check($sformatf("bp%0d_rsp1_neg", i), 32'(rsp1_negative), 1);
      check($sformatf("bp%0d_req0_ready", i), 32'(req0_ready), 0);
      check($sformatf("bp%0d_req1_ready", i), 32'(req1_ready), 0);
      req1_b = 100 + i;
      cyc();
    end
    rsp1_ready = 1'b1;
    cyc();
    check("bp_done_rsp1_valid", 32'(rsp1_valid), 0);
    check("bp_done_req0_ready", 32'(req0_ready), 1);

    // req0 withdraws before acceptance: nothing may change
    req0_valid = 1'b0; #1;
    check("wd_req0_ready", 32'(req0_ready), 0);
    cyc();
    check("wd_aluB", alu_inputB, 16);
    check("wd_rsp0_valid", 32'(rsp0_valid), 0);

    // reset while in RESP
    req0_a = 5; req0_b = 3; req0_op = CU_ADD; req0_valid = 1'b1; rsp0_ready = 1'b0;
    cyc(); req0_valid = 1'b0;
    cyc();
    check("rm_rsp0_valid_pre", 32'(rsp0_valid), 1);
    nRst = 1'b0;
    cyc();
    check("rm_rsp0_valid", 32'(rsp0_valid), 0);
    check("rm_rsp1_valid", 32'(rsp1_valid), 0);
    check("rm_req0_ready", 32'(req0_ready), 0);
    check("rm_req1_ready", 32'(req1_ready), 0);
    check("rm_aluA", alu_inputA, 0);
    check("rm_aluB", alu_inputB, 0);
    check("rm_aluOP", 32'(alu_aluOP), 0);
    check("rm_rsp0_result", rsp0_result, 0);
    check("rm_rsp1_result", rsp1_result, 0);
    nRst = 1'b1; rsp0_ready = 1'b1;
    cyc();
    check("rm_stale_rsp0_valid", 32'(rsp0_valid), 0);
    req0_a = 7; req0_b = 7; req0_op = CU_SUB; req0_valid = 1'b1;
    cyc(); req0_valid = 1'b0;
    cyc();
    check("rm_after_rsp0_valid", 32'(rsp0_valid), 1);
    check("rm_after_result", rsp0_result, 0);
    check("rm_after_zero", 32'(rsp0_zero), 1);
    cyc();
    check("rm_after_idle", 32'(rsp0_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
